dmem_line_latency: RTL

//  Backing data memory for the D-cache: services 256-bit line reads and writes.

---
 rtl/dmem_line_latency.sv | 118 +++++++++++
 1 files changed

// File: rtl/dmem_line_latency.sv
// dmem_line_latency: backing line store for the D-cache.
// Serves 256-bit line reads and writes through the cache's enable/write/ack
// handshake with a fixed access latency of LATENCY cycles (1..255).
// Optional build macro: DMEM_ADDR_CHECK_EN. When it is defined, an out-of-range
// address sets a sticky err_o and the access is suppressed. When it is not
// defined, the upper address bits alias.
module dmem_line_latency #(
  parameter int LATENCY     = 10,
  parameter int DEPTH_LINES = 512,
  parameter int IDX_W       = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  state_e             state;
  logic [7:0]         cnt;
  logic [IDX_W-1:0]   cap_idx;
  logic               cap_wr;
  logic               cap_bad;
  logic [255:0]       cap_data;
  logic [255:0]       mem [DEPTH_LINES];

  logic [IDX_W-1:0]   in_idx;
  logic               in_bad;
  logic               unused_addr;

  assign in_idx = addr_i[IDX_W+4:5];

`ifdef DMEM_ADDR_CHECK_EN
  assign in_bad      = |addr_i[31:IDX_W+5];
  assign unused_addr = ^addr_i[4:0];
`else
  // Upper bits alias onto the array; the byte offset within a line is unused.
  assign in_bad      = 1'b0;
  assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};
`endif

  // Access fired on the edge that enters ACK. With LATENCY==1 that edge is the
  // capture edge itself, so the live inputs are used instead of the captured copy.
  logic               acc_fire;
  logic [IDX_W-1:0]   acc_idx;
  logic               acc_wr;
  logic               acc_bad;
  logic [255:0]       acc_data;

  // Select the request that completes on this edge.
  always_comb begin
    acc_fire = 1'b0;
    acc_idx  = cap_idx;
    acc_wr   = cap_wr;
    acc_bad  = cap_bad;
    acc_data = cap_data;
    if (state == IDLE && enable_i && LATENCY == 1) begin
      acc_fire = 1'b1;
      acc_idx  = in_idx;
      acc_wr   = write_i;
      acc_bad  = in_bad;
      acc_data = data_i;
    end else if (state == BUSY && cnt == 8'd1) begin
      acc_fire = 1'b1;
    end
  end

  // Request FSM, array access and registered outputs. The array sits in the
  // reset block without a reset value, so an asserted reset also blocks any
  // write on that edge. This makes reset win over a completing access.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      ack_o    <= 1'b0;
      data_o   <= '0;
      err_o    <= 1'b0;
      cap_idx  <= '0;
      cap_wr   <= 1'b0;
      cap_bad  <= 1'b0;
      cap_data <= '0;
    end else begin
      ack_o <= 1'b0;
      if (acc_fire) begin
        ack_o <= 1'b1;
        if (acc_wr) begin
          if (!acc_bad) mem[acc_idx] <= acc_data;
        end else begin
          data_o <= acc_bad ? '0 : mem[acc_idx];
        end
      end
      case (state)
        IDLE: if (enable_i) begin
          cap_idx  <= in_idx;
          cap_wr   <= write_i;
          cap_bad  <= in_bad;
          cap_data <= data_i;
          cnt      <= 8'(LATENCY - 1);
          err_o    <= err_o | in_bad;
          state    <= (LATENCY == 1) ? ACK : BUSY;
        end
        BUSY: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
